// File: rtl/alu_stack_ctrl.sv
// Stack-machine sequencer: pops operands from a synchronous stack RAM, runs them
// through the external 16-bit ALU, writes the result back and keeps SP and flags.
module alu_stack_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [3:0]    op_i,
    input  logic          push_i,
    input  logic [15:0]   push_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          zero_o,
    output logic          ovf_o,
    output logic [AW:0]   sp_o,
    output logic [AW-1:0] stack_addr_o,
    output logic          stack_we_o,
    output logic [15:0]   stack_wr_data_o,
    input  logic [15:0]   stack_rd_data_i,
    output logic [15:0]   alu_a_o,
    output logic [15:0]   alu_b_o,
    output logic [3:0]    alu_op_o,
    input  logic [15:0]   alu_s_i,
    input  logic          alu_zero_i,
    input  logic          alu_ofl_i
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, WB, ERR} state_t;

    function automatic logic is_binary(input logic [3:0] op);
        return op <= 4'b0110;
    endfunction

    function automatic logic is_unary(input logic [3:0] op);
        return (op == 4'b0111) || (op == 4'b1001);
    endfunction

    state_t        state_q;
    logic [AW:0]   sp_q;
    logic [3:0]    op_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [15:0]   wr_data_q;
    logic [15:0]   alu_a_q;
    logic [15:0]   alu_b_q;
    logic [3:0]    alu_op_q;
    logic          zf_q;
    logic          of_q;
    logic          zero_q;
    logic          ovf_q;
    logic          done_q;
    logic          err_q;

    logic [AW-1:0] sp_lo;
    logic          sp_full;
    logic          push_acc;
    logic          start_bad;

    assign sp_lo     = sp_q[AW-1:0];
    assign sp_full   = sp_q[AW];
    assign push_acc  = (state_q == IDLE) && push_i && !start_i && !sp_full;
    assign start_bad = (!is_binary(op_i) && !is_unary(op_i))
                     || (is_binary(op_i) && (sp_q < (AW+1)'(2)))
                     || (is_unary(op_i) && (sp_q == '0));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            sp_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wr_data_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q <= op_i;
                        if (start_bad) begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= RD1;
                            addr_q  <= sp_lo - AW'(1);
                        end
                    end else if (push_i) begin
                        if (sp_full) err_q <= 1'b1;
                        else         sp_q  <= sp_q + (AW+1)'(1);
                    end
                end
                RD1: begin
                    if (is_binary(op_q)) begin
                        state_q <= RD2;
                        addr_q  <= sp_lo - AW'(2);
                    end else begin
                        state_q  <= EXEC;
                        alu_b_q  <= '0;
                        alu_op_q <= op_q;
                    end
                end
                RD2: begin
                    // Top of stack arrives first and becomes the B operand.
                    state_q  <= EXEC;
                    alu_b_q  <= stack_rd_data_i;
                    alu_op_q <= op_q;
                end
                EXEC: begin
                    state_q   <= WB;
                    alu_a_q   <= stack_rd_data_i;
                    wr_data_q <= alu_s_i;
                    zf_q      <= alu_zero_i;
                    of_q      <= alu_ofl_i;
                    we_q      <= 1'b1;
                    done_q    <= 1'b1;
                end
                WB: begin
                    state_q <= IDLE;
                    zero_q  <= zf_q;
                    ovf_q   <= of_q;
                    if (is_binary(op_q)) sp_q <= sp_q - (AW+1)'(1);
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pushes write at the accepting edge, so the RAM port is steered combinationally in IDLE.
    assign stack_we_o      = (push_acc || we_q) && !reset_i;
    assign stack_addr_o    = push_acc ? sp_lo : addr_q;
    assign stack_wr_data_o = push_acc ? push_data_i : wr_data_q;

    // Operand A is read in the EXEC cycle itself and fed straight to the ALU.
    assign alu_a_o  = (state_q == EXEC) ? stack_rd_data_i : alu_a_q;
    assign alu_b_o  = alu_b_q;
    assign alu_op_o = alu_op_q;

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign err_o  = err_q;
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;
    assign sp_o   = sp_q;

endmodule

// File: doc/alu_stack_ctrl.md
# alu_stack_ctrl

Sequencer that runs one stack-machine arithmetic instruction through the 16-bit ALU. It reads operands from a synchronous stack RAM, drives the ALU, writes the result back, and maintains the stack pointer and the latched Zero/Overflow flags. It sits between instruction decode (Start/Op, Push/PushData) and the `alu16b` ALU plus the stack RAM.

## Interface
Parameters:
- AW, 8: stack RAM address width. Depth is 2^AW entries.

Ports:
- CLK  in  1  clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  execute Op. Sampled only in IDLE.
- Op  in  4  ALU opcode. Binary ops: 0000 add, 0001 sub, 0010 shl, 0011 shr, 0100 and, 0101 or, 0110 xor. Unary ops: 0111 not, 1001 neg. All other codes are illegal.
- Push  in  1  push PushData. Sampled only in IDLE.
- PushData  in  16  value to push.
- Busy  out  1  high when state ≠ IDLE.
- Done  out  1  one-cycle pulse when a Start command completes, whether or not it errored.
- Err  out  1  one-cycle pulse: underflow, overflow-on-push, or illegal Op.
- Zero  out  1  latched ALU IsZero from the last successful op.
- Ovf  out  1  latched ALU OFL from the last successful op.
- SP  out  AW+1  entry count. Top of stack is at address SP-1.
- StackAddr  out  AW  RAM address. Read data is valid one cycle after the address is driven.
- StackWe  out  1  RAM write enable.
- StackWrData  out  16  RAM write data.
- StackRdData  in  16  RAM read data.
- AluA, AluB  out  16  ALU operands.
- AluOp  out  4  ALU opcode.
- AluS  in  16  ALU result.
- AluZero, AluOfl  in  1  ALU flags.

## Operation
- States: IDLE, RD1, RD2, EXEC, WB, ERR.
- Reset values: state IDLE; SP 0; Busy, Done, Err, Zero, Ovf, StackWe all 0; AluA, AluB 0; AluOp 0000; StackAddr 0. Reset does not clear RAM contents.
- IDLE with Start=1:
  - Latch Op.
  - Illegal Op, binary Op with SP<2, or unary Op with SP<1 → go to ERR.
  - Otherwise → go to RD1.
- Start has priority over a simultaneous Push; the Push is dropped.
- IDLE with Push=1 and Start=0:
  - SP<2^AW: StackWe=1, StackAddr=SP[AW-1:0], StackWrData=PushData, SP+1 at the edge. Stay in IDLE. No Done.
  - SP=2^AW: Err pulse in the next cycle, no write, SP unchanged.
- RD1: StackAddr=SP-1.
  - Binary → go to RD2.
  - Unary → go to EXEC.
- RD2: capture StackRdData into the B register; StackAddr=SP-2; go to EXEC.
- EXEC:
  - Capture StackRdData into the A register. Unary ops capture from the RD1 read; B is forced to 0.
  - AluA=A, AluB=B, AluOp=latched Op.
  - Register AluS, AluZero and AluOfl at the end of the cycle.
  - Go to WB.
- WB:
  - StackWe=1 and StackWrData=registered S.
  - Binary: StackAddr=SP-2, then SP-1 at the edge.
  - Unary: StackAddr=SP-1, SP unchanged.
  - Zero and Ovf load the registered flags. Done=1. Go to IDLE.
- ERR: Done=1, Err=1. No write; SP, Zero and Ovf unchanged. Go to IDLE.
- Start or Push while Busy is ignored, not queued.
- Arithmetic:
  - All arithmetic is 16-bit wrap as produced by the ALU; this block does no recomputation.
  - SP arithmetic is unsigned AW+1 bits and never wraps, because guards prevent it.

## Timing
- Start accepted at edge 0:
  - Binary: RD1 in cycle 1, RD2 in cycle 2, EXEC in cycle 3, WB/Done in cycle 4. Next command can be accepted at edge 5.
  - Unary: Done in cycle 3.
  - Error: ERR/Done in cycle 1.
- Push: write and SP update take effect at the accepting edge. A Push or Start in the very next cycle sees the new SP.
- Zero, Ovf and SP change only on the edge that ends WB (or the Push edge); they are stable at all other times.
- AluA, AluB and AluOp hold their last values outside EXEC.
- Reset high in any state, including mid-op:
  - Next state IDLE; SP 0; no Done.
  - StackWe is 0 in the cycle following the reset edge; a WB in progress is aborted, not committed.

## Test plan
- Push 5, push 3, Start Op=0000 → Done 4 cycles after Start; RAM[0]=8; SP=1; Zero=0; Ovf=0.
- Push 0x7FFF, push 1, Start add → RAM[0]=0x8000; Ovf=1. Then push 0x8000, Start sub → RAM[0]=0x0000; Zero=1; Ovf=0.
- SP=1, Start unary 1001 with RAM[0]=0x0001 → Done 3 cycles after Start; RAM[0]=0xFFFF; SP=1.
- SP=1, Start binary xor → Done and Err in cycle 1; SP=1; no StackWe; flags unchanged. Op=1000 at SP=2 → same error behaviour.
- Start and Push asserted together, then Push during Busy → only the op executes; SP reflects the op alone. Fill the stack to 2^AW, then Push → Err pulse, SP unchanged.
- Reset asserted in WB of an add → StackWe stays 0 and RAM is unchanged; SP=0, Busy=0, Zero=0, Ovf=0 on the next cycle.
